// File: rtl/rb_cfg_pkg.sv
// Shared definitions for the register-bank configuration loader.
package rb_cfg_pkg;

  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_DTC    = 2'b01;
  localparam logic [1:0] OP_BURST  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Command byte layout: [7:6] opcode, [5:3] neuron index, [2] unused, [1:0] field
  localparam int CMD_OP_MSB  = 7;
  localparam int CMD_OP_LSB  = 6;
  localparam int CMD_IDX_MSB = 5;
  localparam int CMD_IDX_LSB = 3;
  localparam int CMD_FLD_MSB = 1;
  localparam int CMD_FLD_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } rb_cfg_state_t;

endpackage

// File: rtl/rb_cfg_loader.sv
// Byte-stream sequencer turning command/data bytes into setup/strobe/hold
// write cycles on the neuron register bank.
//
// state  | meaning
// IDLE   | waiting for a command byte
// DATA   | waiting for the data byte of the current write
// SETUP  | select/data driven, strobes low (1 cycle)
// STROBE | write strobe high for STROBE_LEN cycles
// HOLD   | strobes low, select/data still driven (1 cycle)
module rb_cfg_loader
  import rb_cfg_pkg::*;
#(
  parameter int STROBE_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       abort,
  output logic [7:0] neuron_select,
  output logic [1:0] select,
  output logic       set_data_in,
  output logic       set_din,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] STROBE_LOAD = 2'(STROBE_LEN - 1);

  rb_cfg_state_t state_q, state_d;
  logic [1:0] op_q;
  logic [2:0] idx_q;
  logic [1:0] fld_q;
  logic [2:0] bcnt_q;
  logic [1:0] scnt_q;
  logic       ready_q;
  logic       accept;
  logic       write_phase_d;
  logic [2:0] nidx;

  // abort is the only input allowed to reach an output combinationally
  assign s_ready = ready_q & ~abort;
  assign accept  = s_valid & s_ready;
  assign nidx    = (op_q == OP_BURST) ? bcnt_q : idx_q;
  assign write_phase_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                         (state_d == ST_HOLD);

  // Next-state decode; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (accept && (s_data[CMD_OP_MSB:CMD_OP_LSB] != OP_RSVD)) state_d = ST_DATA;
      ST_DATA:
        if (accept) state_d = ST_SETUP;
      ST_SETUP:
        state_d = ST_STROBE;
      ST_STROBE:
        if (scnt_q == 2'd0) state_d = ST_HOLD;
      ST_HOLD:
        if ((op_q == OP_BURST) && (bcnt_q != 3'd7)) state_d = ST_DATA;
        else                                          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // State, command latches and the strobe/burst counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SINGLE;
      idx_q   <= 3'd0;
      fld_q   <= 2'd0;
      bcnt_q  <= 3'd0;
      scnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && accept) begin
        op_q   <= s_data[CMD_OP_MSB:CMD_OP_LSB];
        idx_q  <= s_data[CMD_IDX_MSB:CMD_IDX_LSB];
        fld_q  <= s_data[CMD_FLD_MSB:CMD_FLD_LSB];
        bcnt_q <= 3'd0;
      end
      if (abort) begin
        bcnt_q <= 3'd0;
      end else if ((state_q == ST_HOLD) && (state_d == ST_DATA)) begin
        bcnt_q <= bcnt_q + 3'd1;
      end
      if (state_q == ST_SETUP)       scnt_q <= STROBE_LOAD;
      else if (state_q == ST_STROBE) scnt_q <= scnt_q - 2'd1;
    end
  end

  // Registered bank-side outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q       <= 1'b0;
      neuron_select <= 8'd0;
      select        <= 2'd0;
      set_data_in   <= 1'b0;
      set_din       <= 1'b0;
      data_in       <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      ready_q       <= (state_d == ST_IDLE) || (state_d == ST_DATA);
      neuron_select <= (write_phase_d && (op_q != OP_DTC)) ? (8'b1 << nidx) : 8'd0;
      if ((state_q == ST_DATA) && (state_d == ST_SETUP)) select <= fld_q;
      set_data_in   <= (state_d == ST_STROBE) && (op_q != OP_DTC);
      set_din       <= (state_d == ST_STROBE) && (op_q == OP_DTC);
      if ((state_q == ST_DATA) && accept) data_in <= s_data;
      busy          <= state_d != ST_IDLE;
      done          <= (state_q == ST_HOLD) && (state_d == ST_IDLE) && !abort;
      err           <= (state_q == ST_IDLE) && accept &&
                       (s_data[CMD_OP_MSB:CMD_OP_LSB] == OP_RSVD);
    end
  end

endmodule

// File: tb/tb_rb_cfg_loader.sv
// Scoreboard bench for rb_cfg_loader: randomized command streams against a
// transaction-level model, plus a STROBE_LEN=3 instance for cycle-pattern checks.
module tb_rb_cfg_loader;

  localparam int SL_MAIN = 1;
  localparam int SL3     = 3;

  typedef struct packed {
    logic       is_dtc;
    logic [7:0] nsel;
    logic [1:0] sel;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, s_valid, abort, s_ready;
  logic [7:0] s_data, neuron_select, data_in;
  logic [1:0] select;
  logic       set_data_in, set_din, busy, done, err;

  logic       rst3, s_valid3, abort3, rdy3;
  logic [7:0] s_data3, nsel3, din3;
  logic [1:0] sel3;
  logic       sdi3, sdn3, busy3, done3, err3;

  rb_cfg_loader #(.STROBE_LEN(SL_MAIN)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .neuron_select(neuron_select), .select(select),
    .set_data_in(set_data_in), .set_din(set_din), .data_in(data_in),
    .busy(busy), .done(done), .err(err)
  );

  rb_cfg_loader #(.STROBE_LEN(SL3)) dut3 (
    .clk(clk), .rst(rst3), .s_data(s_data3), .s_valid(s_valid3), .s_ready(rdy3),
    .abort(abort3), .neuron_select(nsel3), .select(sel3),
    .set_data_in(sdi3), .set_din(sdn3), .data_in(din3),
    .busy(busy3), .done(done3), .err(err3)
  );

  int  checks = 0, errors = 0;
  int  exp_done = 0, exp_err = 0, obs_done = 0, obs_err = 0;
  wr_t exp_q[$];
  logic aborted_win = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard at each strobe start and checks pulse shapes
  logic prev_stb = 1'b0, prev_done = 1'b0, prev_err = 1'b0, stb;
  int   stb_len = 0, win_len = 0;
  wr_t  e;
  always @(negedge clk) begin
    stb = set_data_in | set_din;
    if (stb && !prev_stb) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write nsel=%0h data=%0h required=none", neuron_select, data_in);
      end else begin
        e = exp_q.pop_front();
        chk("wr_kind_dtc", set_din, e.is_dtc);
        chk("wr_nsel", neuron_select, e.nsel);
        chk("wr_data", data_in, e.data);
        if (!e.is_dtc) begin
          chk("wr_sel", select, e.sel);
          chk("strobe_after_setup", win_len, 1);
        end
      end
    end
    if (stb) begin
      stb_len++;
      chk("single_strobe_kind", set_data_in & set_din, 0);
    end else if (prev_stb) begin
      if (!aborted_win) chk("strobe_len", stb_len, SL_MAIN);
      stb_len = 0;
    end
    if (neuron_select != 8'd0) win_len++;
    else if (win_len != 0) begin
      if (!aborted_win) chk("select_window_len", win_len, SL_MAIN + 2);
      aborted_win = 1'b0;
      win_len = 0;
    end
    if (done) begin obs_done++; chk("done_width", prev_done, 0); end
    if (err)  begin obs_err++;  chk("err_width", prev_err, 0); end
    prev_stb  = stb;
    prev_done = done;
    prev_err  = err;
  end

  task automatic send(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) begin
      s_data = 8'($urandom);
      @(negedge clk);
    end
    s_data = b; s_valid = 1'b1; n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout ready=%0b required=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle_and_check();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%0b required=0", busy);
    end
    @(negedge clk); #1;
    chk("done_count", obs_done, exp_done);
    chk("err_count", obs_err, exp_err);
    chk("writes_outstanding", exp_q.size(), 0);
  endtask

  // Reference model: one command plus its data bytes, expressed as bank writes
  task automatic run_cmd(input logic [7:0] cmd, input logic [63:0] d);
    logic [1:0] op  = cmd[7:6];
    logic [2:0] idx = cmd[5:3];
    logic [1:0] fld = cmd[1:0];
    send(cmd);
    case (op)
      2'b00: begin
        exp_q.push_back('{1'b0, 8'(1 << idx), fld, d[7:0]});
        exp_done++;
        send(d[7:0]);
      end
      2'b01: begin
        exp_q.push_back('{1'b1, 8'h00, 2'b00, d[7:0]});
        exp_done++;
        send(d[7:0]);
      end
      2'b10: begin
        exp_done++;
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back('{1'b0, 8'(1 << i), fld, d[8*i +: 8]});
          send(d[8*i +: 8]);
        end
      end
      default: exp_err++;
    endcase
    wait_idle_and_check();
  endtask

  task automatic send3(input logic [7:0] b);
    int n = 0;
    s_data3 = b; s_valid3 = 1'b1;
    while (!rdy3 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send3_timeout ready=%0b required=1", rdy3);
    end
    @(negedge clk);
    s_valid3 = 1'b0;
  endtask

  // Cycle-by-cycle pattern from SETUP onward; optional async reset at step rst_at
  task automatic t3_write(input logic [7:0] cmd, input logic [7:0] d, input int rst_at);
    logic [7:0] nsel_e;
    nsel_e = 8'h01 << cmd[5:3];
    send3(cmd);
    send3(d);
    for (int k = 0; k <= SL3 + 2; k++) begin
      #1;
      if (k == rst_at) begin
        rst3 = 1'b0; #1;
        chk("rst3_async_clear", {nsel3, sel3, sdi3, sdn3, din3, busy3, done3, err3, rdy3}, 0);
        @(negedge clk); rst3 = 1'b1;
        @(negedge clk); #1;
        chk("rst3_ready_back", rdy3, 1);
        return;
      end
      chk("t3_nsel", nsel3, (k <= SL3 + 1) ? nsel_e : 8'h00);
      if (k <= SL3 + 1) chk("t3_sel", sel3, cmd[1:0]);
      chk("t3_strobe", sdi3, (k >= 1 && k <= SL3) ? 1 : 0);
      chk("t3_done", done3, (k == SL3 + 2) ? 1 : 0);
      chk("t3_data", din3, d);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d required=finished", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] d4;
    rst = 1'b0; s_valid = 1'b0; abort = 1'b0; s_data = 8'h00;
    rst3 = 1'b0; s_valid3 = 1'b0; abort3 = 1'b0; s_data3 = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {neuron_select, select, set_data_in, set_din, data_in,
                          busy, done, err, s_ready}, 0);
    rst = 1'b1; rst3 = 1'b1;
    chk("ready_low_before_clock", s_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_first_clock", s_ready, 1);
    @(negedge clk);

    run_cmd(8'h2A, 64'h5C);
    run_cmd(8'h40, 64'h81);
    run_cmd(8'h81, 64'h1716151413121110);
    run_cmd(8'hC3, 64'h0);
    run_cmd(8'h3D, 64'hE4);

    repeat (20) run_cmd(8'($urandom), {$urandom, $urandom});

    // abort and s_valid together in IDLE: byte must not be taken
    s_valid = 1'b1; s_data = 8'h2A; abort = 1'b1; #1;
    chk("abort_gates_ready", s_ready, 0);
    @(negedge clk);
    s_valid = 1'b0; abort = 1'b0; #1;
    chk("abort_blocks_accept", busy, 0);
    @(negedge clk);

    // abort during the strobe of the 4th burst write
    send(8'h8A);
    for (int i = 0; i < 4; i++) begin
      d4 = 8'($urandom);
      exp_q.push_back('{1'b0, 8'(1 << i), 2'd2, d4});
      send(d4);
    end
    @(negedge clk);
    aborted_win = 1'b1;
    abort = 1'b1; #1;
    chk("abort_ready_low", s_ready, 0);
    @(negedge clk);
    abort = 1'b0; #1;
    chk("abort_strobe_low", set_data_in, 0);
    chk("abort_nsel_low", neuron_select, 0);
    chk("abort_idle", busy, 0);
    chk("abort_ready_back", s_ready, 1);
    @(negedge clk); #1;
    chk("abort_no_done", obs_done, exp_done);
    chk("abort_writes_done", exp_q.size(), 0);
    run_cmd(8'h12, 64'h9B);

    // reset in the middle of a strobe
    send(8'h1D);
    exp_q.push_back('{1'b0, 8'h08, 2'd1, 8'h3C});
    send(8'h3C);
    @(negedge clk);
    #2;
    aborted_win = 1'b1;
    rst = 1'b0; #1;
    chk("rst_async_clear", {neuron_select, select, set_data_in, set_din, data_in,
                            busy, done, err, s_ready}, 0);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_ready_low", s_ready, 0);
    @(negedge clk); #1;
    chk("rst_ready_back", s_ready, 1);
    chk("rst_no_done", obs_done, exp_done);
    run_cmd(8'h07, 64'hA5);

    // STROBE_LEN=3 instance
    @(negedge clk);
    t3_write(8'h13, 8'hA7, -1);
    t3_write(8'h2E, 8'h5A, 2);
    t3_write(8'h39, 8'hC6, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rb_cfg_loader.md
# rb_cfg_loader

Byte-stream configuration sequencer that drives the write side of the neuron register bank: `neuron_select`, `select`, `set_data_in`, `set_din` and `data_in`. It accepts command and data bytes over a valid/ready stream, for example from the SPI/UART front end. It decodes single-neuron, DTC and 8-neuron burst writes into setup/strobe/hold write cycles. It sits between the host link and the `registers` block in the neuron grid.

## Interface
Parameters:
- `STROBE_LEN`, default 1: strobe-high duration in cycles. Legal range 1..4.

Ports:
- `clk` input, 1: system clock; all logic is rising-edge.
- `rst` input, 1: asynchronous, active-low reset.
- `s_data` input, 8: stream byte.
- `s_valid` input, 1: byte valid.
- `s_ready` output, 1: byte accepted on a cycle where `s_valid & s_ready`.
- `abort` input, 1: synchronous abort; returns the block to IDLE.
- `neuron_select` output, 8: one-hot neuron enable to the bank.
- `select` output, 2: field code to the bank.
- `set_data_in` output, 1: neuron write strobe.
- `set_din` output, 1: DTC write strobe.
- `data_in` output, 8: write data.
- `busy` output, 1: high in any state other than IDLE.
- `done` output, 1: one-cycle pulse when a command completes.
- `err` output, 1: one-cycle pulse when a reserved opcode is received.

## Operation
Command byte format: opcode = `[7:6]`, neuron index = `[5:3]`, bit `[2]` is ignored, field = `[1:0]`.
- Opcode `00`, SINGLE: the next byte is written to neuron `idx` using field `fld`.
- Opcode `01`, DTC: the next byte is driven with `set_din`. `idx` and `fld` are ignored.
- Opcode `10`, BURST: the next 8 bytes are written to neurons 0..7 in order, all using field `fld`.
- Opcode `11`, reserved: the command byte is consumed, `err` pulses on the next cycle, and the block stays in IDLE.

States: IDLE → DATA → SETUP → STROBE → HOLD → (DATA | IDLE).
- IDLE: `s_ready`=1 (unless `abort`). Accepting a command byte latches opcode, index and field, then moves to DATA. A reserved opcode stays in IDLE.
- DATA: `s_ready`=1. Accepting a byte latches it into `data_in` and moves to SETUP.
- SETUP: outputs `neuron_select`, `select`, `data_in` are valid and stable. Strobes = 0. Lasts 1 cycle.
- STROBE: `set_data_in` (SINGLE/BURST) or `set_din` (DTC) = 1 for `STROBE_LEN` cycles.
- HOLD: strobes = 0, `neuron_select`/`select`/`data_in` unchanged. Lasts 1 cycle.
  - In BURST with burst count < 7: increment the count and return to DATA.
  - Otherwise: go to IDLE and pulse `done` on the cycle of the HOLD→IDLE transition.

Output rules:
- `neuron_select` = `1<<idx` only during SETUP/STROBE/HOLD of SINGLE/BURST writes; 0 at all other times.
- `neuron_select` is 0 throughout DTC writes.
- `data_in` holds the last latched byte indefinitely.
- `s_ready` = 0 in SETUP, STROBE and HOLD.
- `s_ready` = 0 in any cycle where `abort`=1.
- `abort` (any state): the next state is IDLE, all strobes and `neuron_select` drop on the next edge, and no `done` pulse is issued.
  - If `abort` lands mid-burst, writes already strobed remain in the bank.
- `abort` and `s_valid` in the same cycle: `abort` wins; the byte is not accepted.
- `s_valid` low in DATA: the block waits indefinitely; there is no timeout.

Reset values (while `rst`=0): state IDLE, burst count 0, and all outputs 0, including `s_ready`, `data_in` and `select`. `s_ready` rises on the first clock after reset deasserts.

## Timing
- Data byte accepted at edge T:
  - SETUP during cycle T..T+1.
  - Strobe high from T+1 to T+1+`STROBE_LEN`.
  - HOLD for 1 cycle.
  - `s_ready` = 1 again `STROBE_LEN`+2 cycles after T.
- Minimum per-write spacing = `STROBE_LEN`+3 cycles, including the accept cycle.
- SINGLE with `STROBE_LEN`=1: command-to-`done` = 5 cycles of block time, excluding stream stalls.
- BURST with `STROBE_LEN`=1: 1 + 8×4 = 33 cycles minimum.
- All outputs are registered; there are no combinational paths from inputs to outputs except `s_ready` gated by `abort`.

## Structure
- Package `rb_cfg_pkg` contains:
  - opcode constants `OP_SINGLE`, `OP_DTC`, `OP_BURST`, `OP_RSVD`;
  - state enum `rb_cfg_state_t`;
  - field-position constants for the command byte.
- Single module; no sub-module. The strobe counter (2 bits) and the burst counter (3 bits) are inline.

## Test plan
- SINGLE: command `0x2A` (idx 5, fld 2) then data `0x5C` → `neuron_select`=`0x20`, `select`=2, `data_in`=`0x5C` for 3 cycles; `set_data_in` high exactly 1 cycle, in the middle of that window; `done` pulses once.
- DTC: command `0x40` then data `0x81` → `set_din` high 1 cycle with `data_in`=`0x81`; `neuron_select`=0 and `set_data_in`=0 throughout.
- BURST: command `0x81` then bytes `0x10`..`0x17` with `s_valid` toggled randomly → 8 strobes with `neuron_select` `0x01`..`0x80` and the matching data bytes; `done` only after the 8th write.
- Reserved opcode: command `0xC3` → `err` pulses 1 cycle; no strobe; the next command byte is accepted normally.
- Abort: `abort` asserted during the STROBE of the 4th BURST write → neurons 0..3 written; the block returns to IDLE; no `done`; strobes low on the next edge; `s_ready` returns to 1.
- Reset mid-write: drive `rst` low in STROBE → all outputs 0 immediately (asynchronously); after release, a fresh SINGLE write completes correctly. Repeat with `STROBE_LEN`=3 and check a 3-cycle strobe.
